// File: rtl/pla_placa.sv
// Board I/O conditioning: synchronise four async 8-bit ports, derive pass-through, sum, edge count, sticky bits.
// Optional build macro PLA_PLACA_SAT_EN: d1_s saturates at all-ones, d2_s holds at all-ones instead of wrapping.
module pla_placa #(
  parameter int W        = 8,
  parameter int SYNC_LEN = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d0_e,
  input  logic [W-1:0] d1_e,
  input  logic [W-1:0] d2_e,
  input  logic [W-1:0] d3_e,
  output logic [W-1:0] d0_s,
  output logic [W-1:0] d1_s,
  output logic [W-1:0] d2_s,
  output logic [W-1:0] d3_s
);

  localparam logic [W-1:0] ONE = W'(1);

  // Index 0 is the first flop after the pin, SYNC_LEN-1 the stage used downstream.
  logic [SYNC_LEN-1:0][W-1:0] r_sync0;
  logic [SYNC_LEN-1:0][W-1:0] r_sync1;
  logic [SYNC_LEN-1:0][W-1:0] r_sync2;
  logic [SYNC_LEN-1:0][W-1:0] r_sync3;
  logic                       r_prev;

  logic [W-1:0] w_s0;
  logic [W-1:0] w_s1;
  logic [W-1:0] w_s2;
  logic [W-1:0] w_s3;
  logic [W:0]   w_sum;
  logic [W-1:0] w_d1_nxt;
  logic [W-1:0] w_d2_nxt;
  logic         w_rise;
  logic         w_unused_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync0 <= {r_sync0[SYNC_LEN-2:0], d0_e};
      r_sync1 <= {r_sync1[SYNC_LEN-2:0], d1_e};
      r_sync2 <= {r_sync2[SYNC_LEN-2:0], d2_e};
      r_sync3 <= {r_sync3[SYNC_LEN-2:0], d3_e};
    end
  end

  assign w_s0 = r_sync0[SYNC_LEN-1];
  assign w_s1 = r_sync1[SYNC_LEN-1];
  assign w_s2 = r_sync2[SYNC_LEN-1];
  assign w_s3 = r_sync3[SYNC_LEN-1];

  // Only the event line of port 2 drives logic; the other bits are synchronised but unused.
  assign w_unused_s2 = ^w_s2[W-1:1];

  assign w_sum  = {1'b0, w_s0} + {1'b0, w_s1};
  assign w_rise = w_s2[0] & ~r_prev;

`ifdef PLA_PLACA_SAT_EN
  assign w_d1_nxt = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
  assign w_d2_nxt = (&d2_s) ? d2_s : d2_s + ONE;
`else
  assign w_d1_nxt = w_sum[W-1:0];
  assign w_d2_nxt = d2_s + ONE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b0;
      d0_s   <= '0;
      d1_s   <= '0;
      d2_s   <= '0;
      d3_s   <= '0;
    end else begin
      r_prev <= w_s2[0];
      d0_s   <= w_s0;
      d1_s   <= w_d1_nxt;
      if (w_rise) begin
        d2_s <= w_d2_nxt;
      end
      d3_s   <= d3_s | w_s3;
    end
  end

endmodule

// File: tb/tb_pla_placa.sv
// Randomised and directed bench for pla_placa against a cycle-level reference model.
module tb_pla_placa;

  logic       clk;
  logic       reset;
  logic [7:0] d0_e, d1_e, d2_e, d3_e;
  logic [7:0] d0_s, d1_s, d2_s, d3_s;

  int checks   = 0;
  int failures = 0;

`ifdef PLA_PLACA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  pla_placa #(.W(8), .SYNC_LEN(2)) dut (
    .clk  (clk),
    .reset(reset),
    .d0_e (d0_e),
    .d1_e (d1_e),
    .d2_e (d2_e),
    .d3_e (d3_e),
    .d0_s (d0_s),
    .d1_s (d1_s),
    .d2_s (d2_s),
    .d3_s (d3_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each port keeps the samples taken at the last two edges;
  // an output update uses the older one. Reset wipes the sample history.
  logic [7:0] hist [4][2];
  logic [7:0] m_d0, m_d1, m_d2, m_d3;
  bit         m_prev;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [7:0] s [4];
    logic [7:0] in_v [4];
    int sum;
    int cnt;
    in_v[0] = d0_e; in_v[1] = d1_e; in_v[2] = d2_e; in_v[3] = d3_e;
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        hist[p][0] = 8'd0;
        hist[p][1] = 8'd0;
      end
      m_d0 = 0; m_d1 = 0; m_d2 = 0; m_d3 = 0; m_prev = 0;
    end else begin
      for (int p = 0; p < 4; p++) s[p] = hist[p][1];
      m_d0 = s[0];
      sum  = int'(s[0]) + int'(s[1]);
      if (SAT) m_d1 = (sum > 255) ? 8'd255 : 8'(sum);
      else     m_d1 = 8'(sum % 256);
      if (s[2][0] && !m_prev) begin
        cnt = int'(m_d2) + 1;
        if (SAT) m_d2 = (cnt > 255) ? 8'd255 : 8'(cnt);
        else     m_d2 = 8'(cnt % 256);
      end
      m_prev = s[2][0];
      m_d3 = m_d3 | s[3];
      for (int p = 0; p < 4; p++) begin
        hist[p][1] = hist[p][0];
        hist[p][0] = in_v[p];
      end
    end
  endtask

  // One clock: advance the model on the edge, then compare just after it.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("d0_s", d0_s, m_d0);
    check("d1_s", d1_s, m_d1);
    check("d2_s", d2_s, m_d2);
    check("d3_s", d3_s, m_d3);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    d0_e = 0; d1_e = 0; d2_e = 0; d3_e = 0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    d0_e = 8'hFF; d1_e = 8'hFF; d2_e = 8'hFF; d3_e = 8'hFF;
    for (int p = 0; p < 4; p++) begin
      hist[p][0] = 0;
      hist[p][1] = 0;
    end
    m_d0 = 0; m_d1 = 0; m_d2 = 0; m_d3 = 0; m_prev = 0;

    // Reset with all inputs high, then release and watch the latency.
    #1;
    reset = 1'b1;
    cyc();
    check("rst_d0", d0_s, 8'd0);
    check("rst_d1", d1_s, 8'd0);
    check("rst_d2", d2_s, 8'd0);
    check("rst_d3", d3_s, 8'd0);
    reset = 1'b0;
    cycles(2);
    check("rel_d0_early", d0_s, 8'd0);
    cyc();
    check("rel_d0", d0_s, 8'd255);
    check("rel_d2_held_high", d2_s, 8'd1);
    check("rel_d3", d3_s, 8'd255);

    // Latency of a single change on port 0.
    do_reset();
    cycles(4);
    d0_e = 8'hA5;
    cyc();
    check("lat_e1", d0_s, 8'd0);
    cyc();
    check("lat_e2", d0_s, 8'd0);
    cyc();
    check("lat_e3", d0_s, 8'd165);

    // Sum with and without carry.
    d0_e = 8'd200; d1_e = 8'd100;
    cycles(4);
    check("sum_carry", d1_s, SAT ? 8'd255 : 8'd44);
    d0_e = 8'd3; d1_e = 8'd4;
    cycles(4);
    check("sum_small", d1_s, 8'd7);

    // Edge counting: four pulses then a long high level gives five edges.
    do_reset();
    cycles(3);
    for (int k = 0; k < 4; k++) begin
      d2_e = 8'h01; cycles(4);
      d2_e = 8'h00; cycles(4);
    end
    d2_e = 8'h01;
    cycles(20);
    check("edge_count", d2_s, 8'd5);
    d2_e = 8'hFE;
    cycles(6);
    check("edge_upper_bits", d2_s, 8'd5);

    // Sticky capture of a walking bit.
    do_reset();
    d3_e = 8'd0;
    cycles(4);
    check("sticky_0", d3_s, 8'd0);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] exp_v;
      exp_v = 8'((1 << (k + 1)) - 1);
      d3_e = 8'(1 << k);
      cycles(4);
      check("sticky_walk", d3_s, exp_v);
    end
    d3_e = 8'd0;
    cycles(6);
    check("sticky_hold", d3_s, 8'd31);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("sticky_reset", d3_s, 8'd0);

    // 256 edges: wraps to zero, or pins at 255 when saturating.
    do_reset();
    cycles(3);
    for (int k = 0; k < 256; k++) begin
      d2_e = 8'h01; cycles(2);
      d2_e = 8'h00; cycles(2);
    end
    cycles(4);
    check("edge_wrap", d2_s, SAT ? 8'd255 : 8'd0);

    // Random traffic with occasional mid-operation resets.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      d0_e  = 8'($urandom);
      d1_e  = 8'($urandom);
      d2_e  = {7'($urandom), ($urandom_range(0, 3) == 0) ? ~d2_e[0] : d2_e[0]};
      d3_e  = ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
